// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings, instruction codes and default widths.
package jtag_pkg;

  localparam int unsigned IR_WIDTH_DEFAULT = 4;
  localparam int unsigned TAP_STATE_W      = 4;

  // IEEE 1149.1 TAP state encodings
  typedef enum logic [3:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SH_DR    = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SH_IR    = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  // Instruction codes shared with the instruction decoder
  localparam logic [3:0] INSTR_BYPASS         = 4'hF;
  localparam logic [3:0] INSTR_SAMPLE_PRELOAD = 4'h1;
  localparam logic [3:0] INSTR_IDCODE         = 4'h2;
  localparam logic [3:0] INSTR_EXTEST         = 4'h4;
  localparam logic [3:0] INSTR_INTEST         = 4'h8;

endpackage

// File: rtl/tap_fsm.sv
// TAP state machine: state register, TMS next-state graph and registered DR strobes.
module tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_tck,
  input  logic       i_trst_n,
  input  logic       i_tms,
  output logic [3:0] o_state,
  output logic [3:0] o_next_state,
  output logic       o_capture_dr,
  output logic       o_shift_dr,
  output logic       o_update_dr,
  output logic       o_tlr
);

  tap_state_e r_state;
  tap_state_e w_next_state;
  logic       r_capture_dr;
  logic       r_shift_dr;
  logic       r_update_dr;
  logic       r_tlr;

  // State register; strobes registered from the next state so they align with TAP_STATE
  always_ff @(posedge i_tck or negedge i_trst_n) begin
    if (!i_trst_n) begin
      r_state      <= ST_TLR;
      r_capture_dr <= 1'b0;
      r_shift_dr   <= 1'b0;
      r_update_dr  <= 1'b0;
      r_tlr        <= 1'b1;
    end else begin
      r_state      <= w_next_state;
      r_capture_dr <= (w_next_state == ST_CAP_DR);
      r_shift_dr   <= (w_next_state == ST_SH_DR);
      r_update_dr  <= (w_next_state == ST_UPD_DR);
      r_tlr        <= (w_next_state == ST_TLR);
    end
  end

  // Standard 1149.1 TMS transition graph
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_TLR:      w_next_state = i_tms ? ST_TLR    : ST_RTI;
      ST_RTI:      w_next_state = i_tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR:   w_next_state = i_tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR:   w_next_state = i_tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:    w_next_state = i_tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR:   w_next_state = i_tms ? ST_UPD_DR : ST_PAUSE_DR;
      ST_PAUSE_DR: w_next_state = i_tms ? ST_EX2_DR : ST_PAUSE_DR;
      ST_EX2_DR:   w_next_state = i_tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR:   w_next_state = i_tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR:   w_next_state = i_tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR:   w_next_state = i_tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:    w_next_state = i_tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR:   w_next_state = i_tms ? ST_UPD_IR : ST_PAUSE_IR;
      ST_PAUSE_IR: w_next_state = i_tms ? ST_EX2_IR : ST_PAUSE_IR;
      ST_EX2_IR:   w_next_state = i_tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR:   w_next_state = i_tms ? ST_SEL_DR : ST_RTI;
      default:     w_next_state = ST_TLR;
    endcase
  end

  assign o_state      = r_state;
  assign o_next_state = w_next_state;
  assign o_capture_dr = r_capture_dr;
  assign o_shift_dr   = r_shift_dr;
  assign o_update_dr  = r_update_dr;
  assign o_tlr        = r_tlr;

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP controller: TAP FSM, instruction shift/update register and TDO mux.
// Build option: define TDO_NEGEDGE_EN to register TDO/TDO_EN on falling TCK.
module tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned           IR_WIDTH        = IR_WIDTH_DEFAULT,
  parameter logic [IR_WIDTH-1:0]   IR_RESET_CODE   = IR_WIDTH'(INSTR_IDCODE),
  parameter logic [IR_WIDTH-1:0]   IR_CAPTURE_CODE = IR_WIDTH'(4'h1)
) (
  input  logic                TCK,
  input  logic                TRST_N,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                DR_TDO,
  output logic [IR_WIDTH-1:0] INSTR_REG,
  output logic [3:0]          TAP_STATE,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR,
  output logic                TEST_LOGIC_RESET,
  output logic                TDO,
  output logic                TDO_EN
);

  logic [3:0]          w_state;
  logic [3:0]          w_next_state;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_instr;
  logic                w_tdo;
  logic                w_tdo_en;

  tap_fsm u_fsm (
    .i_tck        (TCK),
    .i_trst_n     (TRST_N),
    .i_tms        (TMS),
    .o_state      (w_state),
    .o_next_state (w_next_state),
    .o_capture_dr (CAPTURE_DR),
    .o_shift_dr   (SHIFT_DR),
    .o_update_dr  (UPDATE_DR),
    .o_tlr        (TEST_LOGIC_RESET)
  );

  // IR shift register: capture fixed pattern, shift right with TDI into the MSB
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_ir_sr <= IR_CAPTURE_CODE;
    end else if (w_state == ST_CAP_IR) begin
      r_ir_sr <= IR_CAPTURE_CODE;
    end else if (w_state == ST_SH_IR) begin
      r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
    end
  end

  // Instruction register: reset code whenever TLR is entered or held, else update on leaving UpdIR
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_instr <= IR_RESET_CODE;
    end else if (w_next_state == ST_TLR) begin
      r_instr <= IR_RESET_CODE;
    end else if (w_state == ST_UPD_IR) begin
      r_instr <= r_ir_sr;
    end
  end

  // Serial-out source select: IR LSB in ShIR, selected DR in ShDR, otherwise idle
  always_comb begin
    w_tdo    = 1'b0;
    w_tdo_en = 1'b0;
    if (w_state == ST_SH_IR) begin
      w_tdo    = r_ir_sr[0];
      w_tdo_en = 1'b1;
    end else if (w_state == ST_SH_DR) begin
      w_tdo    = DR_TDO;
      w_tdo_en = 1'b1;
    end
  end

`ifdef TDO_NEGEDGE_EN
  logic r_tdo;
  logic r_tdo_en;

  // Launch TDO on falling TCK so the next device samples it cleanly on the rising edge
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo;
      r_tdo_en <= w_tdo_en;
    end
  end

  assign TDO    = r_tdo;
  assign TDO_EN = r_tdo_en;
`else
  assign TDO    = w_tdo;
  assign TDO_EN = w_tdo_en;
`endif

  assign INSTR_REG = r_instr;
  assign TAP_STATE = w_state;

endmodule

// File: doc/tap_controller.md
# tap_controller

IEEE 1149.1 Test Access Port controller for the JTAG block. It runs the 16-state TAP state machine from TMS, owns the 4-bit instruction shift/update register, and drives the instruction code into the instruction decoder. It also generates the Capture/Shift/Update-DR strobes for the bypass, device-ID and boundary-scan registers, and muxes their serial outputs onto TDO.

## Interface
Parameters:
- IR_WIDTH, 4, instruction register width
- IR_RESET_CODE, 4'h2, INSTR_REG value in Test-Logic-Reset (IDCODE)
- IR_CAPTURE_CODE, 4'h1, value loaded in Capture-IR (LSBs must be 01)

Ports:
- TCK  input  1  test clock; the only clock
- TRST_N  input  1  asynchronous, active-low reset
- TMS  input  1  mode select, sampled on rising TCK
- TDI  input  1  serial data in
- DR_TDO  input  1  serial out of the data register currently selected by the decoder
- INSTR_REG  output  IR_WIDTH  current instruction, to the decoder
- TAP_STATE  output  4  current state encoding
- CAPTURE_DR  output  1  high while in Capture-DR
- SHIFT_DR  output  1  high while in Shift-DR
- UPDATE_DR  output  1  high while in Update-DR
- TEST_LOGIC_RESET  output  1  high while in Test-Logic-Reset
- TDO  output  1  serial out
- TDO_EN  output  1  TDO driver enable

## Operation
- State encoding follows 1149.1:
  - TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D
- Transitions are the standard TMS graph:
  - TLR: TMS=0 goes to RTI.
  - SelIR: TMS=1 goes to TLR.
  - Shift/Pause states: hold on TMS=0 (ShDR/ShIR) or TMS=0 (Pause).
  - Update states: TMS=0 goes to RTI, TMS=1 goes to SelDR.
  - Five consecutive TMS=1 reach TLR from any state.
- IR shift register (ir_sr):
  - CapIR loads IR_CAPTURE_CODE.
  - ShIR shifts right: TDI enters the MSB and ir_sr[0] is the serial out.
  - All other states hold.
- INSTR_REG:
  - Loaded from ir_sr on the rising edge that leaves UpdIR.
  - Forced to IR_RESET_CODE while in TLR.
- TDO source:
  - ShIR selects ir_sr[0].
  - ShDR selects DR_TDO.
  - Otherwise TDO=0 and TDO_EN=0.
- DR strobes are decoded from the state register. The data register acts on the rising edge at the end of the strobed state.
- Reset: TRST_N low immediately forces TLR regardless of the current state (including mid-shift). This sets ir_sr=IR_CAPTURE_CODE, INSTR_REG=IR_RESET_CODE, TDO=0, TDO_EN=0.

## Timing
- State, ir_sr and INSTR_REG update on rising TCK.
- Strobes and TAP_STATE are valid one clock-to-out after the rising edge that enters the state.
- INSTR_REG changes on the rising edge that leaves UpdIR, one cycle after the UpdIR entry edge.
- IR/DR shift: one bit per rising edge while in a Shift state. The edge that exits Shift to Ex1 (TMS=1) also shifts.
- Pause/Exit2 states preserve ir_sr contents unchanged.
- TRST_N assertion is asynchronous. Release is sampled at the next rising TCK; the FSM stays in TLR while TMS=1.

## Configuration
- TDO_NEGEDGE_EN defined:
  - TDO and TDO_EN are registered on falling TCK, per 1149.1.
  - Reset value is 0.
  - They are delayed half a TCK after the shift edge.
- TDO_NEGEDGE_EN undefined:
  - TDO and TDO_EN are combinational from the state and the selected source.
  - They are valid in the same cycle (for simulation and internal-chain use).

## Structure
- Package jtag_pkg holds:
  - the 16 state localparams
  - instruction codes: BYPASS 4'hF, SAMPLE_PRELOAD 4'h1, IDCODE 4'h2, EXTEST 4'h4, INTEST 8'h8 → 4'h8
  - IR_WIDTH default
  - these are shared with the decoder.
- Sub-module tap_fsm contains the state register, next-state logic and strobe decode.
- tap_controller contains ir_sr, INSTR_REG and the TDO mux.

## Test plan
- Async reset: assert TRST_N=0 mid-ShDR, between clock edges.
  - Immediately: TAP_STATE=F, INSTR_REG=4'h2, TDO_EN=0.
- Recovery from PauseIR: hold TMS=1 for 5 edges, TRST_N high.
  - Result: TAP_STATE=F and INSTR_REG=4'h2.
- IR load: from RTI apply TMS 1,1,0,0 to reach ShIR. Shift TDI=1 x4 with TMS=1 on the 4th bit, then TMS 1,0.
  - TDO must read 1,0,0,0.
  - INSTR_REG=4'hF after leaving UpdIR.
- DR shift: from RTI apply TMS 1,0,0 to reach ShDR. Drive DR_TDO=8'hA5 LSB-first for 8 bits.
  - SHIFT_DR high exactly 8 cycles.
  - TDO reproduces 1,0,1,0,0,1,0,1 (half-cycle delayed with TDO_NEGEDGE_EN).
  - CAPTURE_DR and UPDATE_DR each high exactly one cycle.
- Pause round trip: load 2 IR bits, go Ex1IR→PauseIR (3 cycles)→Ex2IR→ShIR, then load 2 more bits with value 4'h4 total.
  - After update: INSTR_REG=4'h4.
- UpdIR with TMS=1:
  - Next state is SelDR (7).
  - INSTR_REG updates.
  - No DR strobe fires.
